lw_hmac_arbiter: RTL and testbench
==================================

# lw_hmac_arbiter

Shares a single lw_hmac core between two independent requesters (bus-side control logic and a secondary engine such as a DMA or key-derivation sequencer) at whole-message granularity. It grants the core to one requester at a time, round-robin, and sequences start, data, last and done for that message. It isolates the idle requester and recovers the core via abort on requester abort, core fault or stall timeout. It sits between the requesters' native HMAC interfaces and the lw_hmac core instance.

## Interface
- WORD_SIZE, 32: data word width, equal to the core's ARCH_SZ.
- TIMEOUT_CYCLES, 1024: stall watchdog limit in cycles, minimum 2. Only used with the watchdog compiled in.
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i[r]  in  2  level request for a message slot, r in {0,1}.
- opcode_i[r]  in  2x4  opcode of requester r, sampled at grant.
- valid_i[r], last_i[r], abort_i[r]  in  2 each  per-requester data valid, final word, abort.
- data_i[r]  in  2xWORD_SIZE  per-requester data word.
- gnt_o  out  2  one-hot grant (registered).
- ready_o  out  2  per-requester data ready: core_ready_i gated by grant and STREAM state.
- done_o, err_o  out  2 each  one-cycle completion / error pulse to the owner.
- core_start_o, core_valid_o, core_last_o, core_abort_o  out  1 each  core controls.
- core_opcode_o  out  4  latched opcode of the owner.
- core_data_o  out  WORD_SIZE  owner's data, muxed.
- core_ready_i, core_idle_i, core_done_i, core_fault_i  in  1 each  core ready_o, core_ready_o, done_o, fault_inj_det_o.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, START, STREAM, WAIT_DONE, ABORT.
- IDLE: if any req_i and core_idle_i, pick the owner.
  - Both requesting: pick the requester after rr_last.
  - One requesting: pick it.
  - Set gnt_o, latch opcode, go to START.
- START: core_start_o = 1 for exactly one cycle, then go to STREAM.
- STREAM:
  - core_valid_o = valid_i[owner] & core_ready_i.
  - core_data_o and core_last_o come from the owner.
  - A word transfers when valid_i[owner] & ready_o[owner].
  - A transfer with last_i = 1 goes to WAIT_DONE.
- WAIT_DONE: ready_o = 0. On core_done_i:
  - done_o[owner] = 1 for one cycle; core hash is valid to the owner that cycle.
  - Set rr_last = owner, clear gnt_o, go to IDLE.
- ABORT: entered from START, STREAM or WAIT_DONE on any of:
  - abort_i[owner];
  - core_fault_i;
  - watchdog expiry.
- ABORT behaviour:
  - core_abort_o = 1 until core_idle_i.
  - err_o[owner] pulses once on entry; abort_i alone gives no err pulse.
  - Then rr_last = owner, release, go to IDLE.
- Non-owner: ready_o = 0, done_o = 0, err_o = 0. Its valid, abort and data are ignored.
- Dropping req_i mid-message has no effect; only abort_i cancels a message.
- Simultaneous core_done_i and abort_i in WAIT_DONE: done wins, abort is ignored.
- core_fault_i has priority over everything, in every non-IDLE state.

## Timing
- Reset values: state IDLE; gnt_o = 0; rr_last = 1, so requester 0 wins the first tie; every other output 0.
- Grant latency: req_i high in IDLE at cycle N (core idle) gives gnt_o at N+1, core_start_o at N+1, ready_o possible from N+2.
- Data path is combinational owner to core; no added latency, no buffering.
- done_o is registered: core_done_i at cycle M gives done_o at M+1. Re-arbitration is possible from M+2.
- Back-to-back messages: the same requester may regain the core only if the other is not requesting.
- reset_i mid-message: immediate return to IDLE with all outputs 0. The arbiter does not drive core_abort_o; the core is reset by the system.

## Configuration
- LW_HMAC_ARB_WATCHDOG_EN defined:
  - A counter runs in STREAM and WAIT_DONE.
  - It clears on every accepted word and on entry to each of those states.
  - Reaching TIMEOUT_CYCLES forces ABORT with err_o[owner].
- Undefined: no counter logic; ABORT is entered only by abort_i or core_fault_i.

## Test plan
- Single message: req_i = 01, 3 words, last on word 3 → start 1 cycle after request, 3 core_valid_o pulses, done_o = 01 one cycle after core_done_i, gnt_o = 00.
- Contention: req_i = 11 from reset → requester 0 served first, then requester 1 with no idle cycle of arbitration beyond IDLE. Repeat → order 0,1,0,1.
- Isolation: requester 1 drives valid_i and abort_i while 0 owns → core unaffected, ready_o[1] = 0, no done_o[1].
- Requester abort in STREAM after 2 words → core_abort_o held until core_idle_i, no err_o, grant passes to a pending requester.
- core_fault_i in WAIT_DONE → err_o[owner] single pulse, core_abort_o asserted, done_o never raised.
- Watchdog (macro on, TIMEOUT_CYCLES = 16): owner stops driving valid after start → ABORT exactly 16 cycles after the last progress, err_o pulse. Macro off → core stays in STREAM indefinitely.

Source files
------------

// File: rtl/lw_hmac_arbiter.sv
// Purpose: grants one shared lw_hmac core to one of two requesters per message (round-robin), with abort/fault recovery.
// Latency: grant and core_start_o one cycle after request; data/valid/last/ready combinational; done_o/err_o registered (+1).
// Backpressure: core_ready_i passes straight through to the owner's ready_o in STREAM; the idle requester always sees ready_o = 0.
// Optional stall watchdog compiled in with `define LW_HMAC_ARB_WATCHDOG_EN (limit TIMEOUT_CYCLES).
module lw_hmac_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                req_i,
    input  logic [1:0][3:0]           opcode_i,
    input  logic [1:0]                valid_i,
    input  logic [1:0]                last_i,
    input  logic [1:0]                abort_i,
    input  logic [1:0][WORD_SIZE-1:0] data_i,
    output logic [1:0]                gnt_o,
    output logic [1:0]                ready_o,
    output logic [1:0]                done_o,
    output logic [1:0]                err_o,
    output logic                      core_start_o,
    output logic                      core_valid_o,
    output logic                      core_last_o,
    output logic                      core_abort_o,
    output logic [3:0]                core_opcode_o,
    output logic [WORD_SIZE-1:0]      core_data_o,
    input  logic                      core_ready_i,
    input  logic                      core_idle_i,
    input  logic                      core_done_i,
    input  logic                      core_fault_i,
    output logic                      busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_ABORT
    } state_t;

    state_t state_q, state_d;
    logic   owner_q;      // index of the current owner, valid while gnt_o != 0
    logic   rr_last_q;    // last requester served; the other one wins a tie
    logic   pick;
    logic   grant;
    logic   release_en;
    logic   set_done;
    logic   set_err;
    logic   in_stream;
    logic   accept;
    logic   wd_expire;

    assign in_stream = (state_q == ST_STREAM);
    assign accept    = core_valid_o;

    // Owner-to-core data path: purely combinational, nothing leaks outside STREAM
    always_comb begin
        ready_o      = (in_stream && core_ready_i) ? gnt_o : 2'b00;
        core_valid_o = in_stream & core_ready_i & valid_i[owner_q];
        core_last_o  = in_stream & last_i[owner_q];
        core_data_o  = in_stream ? data_i[owner_q] : '0;
        core_start_o = (state_q == ST_START);
        core_abort_o = (state_q == ST_ABORT);
        busy_o       = (state_q != ST_IDLE);
    end

    // Round-robin choice: on a tie take the requester not served last
    always_comb begin
        pick = req_i[1];
        if (req_i == 2'b11) begin
            pick = ~rr_last_q;
        end
    end

`ifdef LW_HMAC_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wd_cnt_q;
    logic             wd_active;

    assign wd_active = (state_q == ST_STREAM) || (state_q == ST_WAIT_DONE);
    assign wd_expire = wd_active && !accept && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: restarts on state entry and on every accepted word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
        end else if (!wd_active || accept || (state_d != state_q)) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end
`else
    // No watchdog: only abort_i or a core fault can cancel a message; the limit has no effect
    assign wd_expire = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

    // Next-state logic; fault outranks everything, done outranks a same-cycle abort
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        release_en = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((req_i != 2'b00) && core_idle_i) begin
                    grant   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (core_fault_i) begin
                    state_d = ST_ABORT;
                    set_err = 1'b1;
                end else if (abort_i[owner_q]) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (core_fault_i) begin
                    state_d = ST_ABORT;
                    set_err = 1'b1;
                end else if (abort_i[owner_q]) begin
                    state_d = ST_ABORT;
                end else if (accept && last_i[owner_q]) begin
                    state_d = ST_WAIT_DONE;
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                    set_err = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (core_fault_i) begin
                    state_d = ST_ABORT;
                    set_err = 1'b1;
                end else if (core_done_i) begin
                    state_d    = ST_IDLE;
                    set_done   = 1'b1;
                    release_en = 1'b1;
                end else if (abort_i[owner_q]) begin
                    state_d = ST_ABORT;
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                    set_err = 1'b1;
                end
            end
            ST_ABORT: begin
                if (core_idle_i) begin
                    state_d    = ST_IDLE;
                    release_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant bookkeeping and the registered done/err pulses
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
            gnt_o         <= 2'b00;
            core_opcode_o <= 4'h0;
            done_o        <= 2'b00;
            err_o         <= 2'b00;
        end else begin
            state_q <= state_d;
            done_o  <= 2'b00;
            err_o   <= 2'b00;
            if (grant) begin
                owner_q       <= pick;
                gnt_o         <= pick ? 2'b10 : 2'b01;
                core_opcode_o <= opcode_i[pick];
            end
            if (release_en) begin
                rr_last_q <= owner_q;
                gnt_o     <= 2'b00;
            end
            if (set_done) begin
                done_o <= owner_q ? 2'b10 : 2'b01;
            end
            if (set_err) begin
                err_o <= owner_q ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_lw_hmac_arbiter.sv
// Purpose: directed self-checking bench for lw_hmac_arbiter (grant, contention, isolation, abort, fault, watchdog, reset).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: core side modelled by hand per step; one stalled core_ready_i cycle is exercised.
module tb_lw_hmac_arbiter;

    localparam int W = 32;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [1:0]          req_i;
    logic [1:0][3:0]     opcode_i;
    logic [1:0]          valid_i, last_i, abort_i;
    logic [1:0][W-1:0]   data_i;
    logic [1:0]          gnt_o, ready_o, done_o, err_o;
    logic                core_start_o, core_valid_o, core_last_o, core_abort_o;
    logic [3:0]          core_opcode_o;
    logic [W-1:0]        core_data_o;
    logic                core_ready_i, core_idle_i, core_done_i, core_fault_i;
    logic                busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    lw_hmac_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .opcode_i(opcode_i),
        .valid_i(valid_i), .last_i(last_i), .abort_i(abort_i), .data_i(data_i),
        .gnt_o(gnt_o), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
        .core_start_o(core_start_o), .core_valid_o(core_valid_o),
        .core_last_o(core_last_o), .core_abort_o(core_abort_o),
        .core_opcode_o(core_opcode_o), .core_data_o(core_data_o),
        .core_ready_i(core_ready_i), .core_idle_i(core_idle_i),
        .core_done_i(core_done_i), .core_fault_i(core_fault_i), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        req_i = '0; valid_i = '0; last_i = '0; abort_i = '0;
        core_done_i = 1'b0; core_fault_i = 1'b0; core_idle_i = 1'b1; core_ready_i = 1'b1;
        tick();
        sample();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ctrl", {core_start_o, core_valid_o, core_last_o, core_abort_o}, 0);
        chk("rst_pulses", {done_o, err_o, ready_o}, 0);
        chk("rst_opcode", core_opcode_o, 0);
        chk("rst_data", core_data_o, 0);
        reset_i = 1'b0;
        tick();
    endtask

    // One whole message for requester own; entered in the arbitration (IDLE) cycle,
    // returns in the IDLE cycle that shows done_o, where the next arbitration happens.
    task automatic msg(input int own, input logic [3:0] opc, input int nw);
        logic [1:0] oh;
        logic [31:0] word;
        oh = (own == 1) ? 2'b10 : 2'b01;
        tick();
        sample();
        chk("start_gnt", gnt_o, oh);
        chk("start_pulse", core_start_o, 1);
        chk("start_opcode", core_opcode_o, opc);
        core_idle_i = 1'b0;
        tick();
        for (int i = 0; i < nw; i++) begin
            word = 32'hD000_0000 + 32'(own * 16 + i);
            valid_i[own] = 1'b1;
            last_i[own]  = (i == nw - 1);
            data_i[own]  = word;
            sample();
            chk("stream_ready", ready_o, oh);
            chk("stream_valid", core_valid_o, 1);
            chk("stream_data", core_data_o, word);
            chk("stream_last", core_last_o, (i == nw - 1));
            chk("stream_noabort", core_abort_o, 0);
            tick();
        end
        valid_i[own] = 1'b0;
        last_i[own]  = 1'b0;
        core_done_i  = 1'b1;
        sample();
        chk("wait_ready", ready_o, 2'b00);
        chk("wait_done_early", done_o, 2'b00);
        tick();
        core_done_i = 1'b0;
        core_idle_i = 1'b1;
        sample();
        chk("done_pulse", done_o, oh);
        chk("done_gnt", gnt_o, 2'b00);
    endtask

    initial begin
        opcode_i = '0;
        data_i   = '0;
        do_reset();

        // Single message from requester 0, three words
        req_i = 2'b01;
        opcode_i[0] = 4'h5;
        sample();
        chk("idle_gnt", gnt_o, 0);
        chk("idle_start", core_start_o, 0);
        msg(0, 4'h5, 3);
        req_i = 2'b00;
        tick();
        sample();
        chk("single_done_once", done_o, 0);
        chk("single_busy", busy_o, 0);

        // Contention from reset: order 0,1,0,1 with back-to-back grants
        do_reset();
        req_i = 2'b11;
        opcode_i[0] = 4'h1;
        opcode_i[1] = 4'h2;
        msg(0, 4'h1, 2);
        msg(1, 4'h2, 2);
        msg(0, 4'h1, 1);
        msg(1, 4'h2, 1);

        // Isolation: requester 1 drives valid/abort/data while 0 owns
        req_i = 2'b01;
        valid_i[1] = 1'b1;
        abort_i[1] = 1'b1;
        data_i[1]  = 32'hBAD0_BAD0;
        opcode_i[0] = 4'h3;
        msg(0, 4'h3, 2);
        valid_i[1] = 1'b0;
        abort_i[1] = 1'b0;

        // Requester abort in STREAM after two words; requester 0 pending
        req_i = 2'b11;
        tick();
        sample();
        chk("ab_gnt", gnt_o, 2'b10);
        core_idle_i = 1'b0;
        tick();
        valid_i[1] = 1'b1; data_i[1] = 32'hE0;
        sample();
        chk("ab_w0", core_valid_o, 1);
        tick();
        data_i[1] = 32'hE1;
        sample();
        chk("ab_w1", core_data_o, 32'hE1);
        tick();
        core_ready_i = 1'b0; data_i[1] = 32'hE2;
        sample();
        chk("ab_stall", {ready_o, core_valid_o}, 3'b000);
        tick();
        core_ready_i = 1'b1; valid_i[1] = 1'b0; abort_i[1] = 1'b1;
        sample();
        chk("ab_req_cycle", core_abort_o, 0);
        tick();
        abort_i[1] = 1'b0;
        sample();
        chk("ab_entry", {core_abort_o, err_o, gnt_o}, 5'b1_00_10);
        tick();
        core_idle_i = 1'b1;
        sample();
        chk("ab_hold", {core_abort_o, err_o}, 3'b1_00);
        tick();
        sample();
        chk("ab_release", {core_abort_o, err_o, gnt_o, busy_o}, 6'b0_00_00_0);
        req_i = 2'b01;
        tick();
        sample();
        chk("ab_pass_gnt", {gnt_o, core_start_o}, 3'b01_1);

        // Core fault in WAIT_DONE for owner 0
        core_idle_i = 1'b0;
        tick();
        valid_i[0] = 1'b1; last_i[0] = 1'b1; data_i[0] = 32'hF0;
        sample();
        chk("ft_last", {core_valid_o, core_last_o}, 2'b11);
        tick();
        valid_i[0] = 1'b0; last_i[0] = 1'b0; req_i = 2'b00; core_fault_i = 1'b1;
        sample();
        chk("ft_wait", {done_o, ready_o}, 4'b0000);
        tick();
        core_fault_i = 1'b0;
        sample();
        chk("ft_entry", {core_abort_o, err_o, done_o}, 5'b1_01_00);
        tick();
        core_idle_i = 1'b1;
        sample();
        chk("ft_single_pulse", {core_abort_o, err_o, done_o}, 5'b1_00_00);
        tick();
        sample();
        chk("ft_release", {core_abort_o, gnt_o, done_o, err_o, busy_o}, 8'b0);

        // Owner goes silent after start: watchdog (if built) or indefinite STREAM
        req_i = 2'b01;
        tick();
        core_idle_i = 1'b0;
        req_i = 2'b00;
        tick();
        for (int k = 0; k < 16; k++) begin
            sample();
            chk("wd_pre", {core_abort_o, err_o, ready_o}, 5'b0_00_01);
            tick();
        end
        sample();
`ifdef LW_HMAC_ARB_WATCHDOG_EN
        chk("wd_fire", {core_abort_o, err_o}, 3'b1_01);
        core_idle_i = 1'b1;
        tick();
        sample();
        chk("wd_release", {busy_o, gnt_o}, 3'b0_00);
`else
        chk("wd_off", {core_abort_o, err_o, ready_o}, 5'b0_00_01);
        repeat (30) tick();
        sample();
        chk("wd_off_long", {busy_o, ready_o, core_abort_o}, 4'b1_01_0);
`endif

        // Reset mid-message (or after release) clears everything
        do_reset();
        sample();
        chk("post_reset_idle", {busy_o, gnt_o}, 3'b0_00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
